// File: rtl/cs_address_sequencer.sv
// Control-store microsequencer: picks the next control-store address from the
// branch select, tracks whether the ROM request is outstanding, traps on an
// illegal select and counts retired microinstructions (saturating).
module cs_address_sequencer #(
  parameter int DATAWIDTH_ADDR   = 11,
  parameter int DATAWIDTH_SEL    = 2,
  parameter int DATAWIDTH_DECODE = 8,
  parameter int DATAWIDTH_COUNT  = 16
) (
  input  logic                        Seq_CLOCK_50,
  input  logic                        Seq_RESET_InHigh,
  input  logic [DATAWIDTH_SEL-1:0]    Seq_Select,
  input  logic [DATAWIDTH_ADDR-1:0]   Seq_JumpAddr,
  input  logic [DATAWIDTH_DECODE-1:0] Seq_DecodeBits,
  input  logic                        Seq_RomReady,
  output logic [DATAWIDTH_ADDR-1:0]   Seq_Addr,
  output logic                        Seq_AddrValid,
  output logic                        Seq_Trap,
  output logic [DATAWIDTH_COUNT-1:0]  Seq_CycleCount
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_HALT = 2'd2
  } state_t;

  localparam logic [DATAWIDTH_SEL-1:0] SEL_NEXT   = DATAWIDTH_SEL'(0);
  localparam logic [DATAWIDTH_SEL-1:0] SEL_JUMP   = DATAWIDTH_SEL'(1);
  localparam logic [DATAWIDTH_SEL-1:0] SEL_DECODE = DATAWIDTH_SEL'(2);

  state_t                       state, state_nxt;
  logic [DATAWIDTH_ADDR-1:0]    addr_nxt;
  logic                         valid_nxt;
  logic                         trap_nxt;
  logic [DATAWIDTH_COUNT-1:0]   count_nxt;
  logic                         retire;

  // A microinstruction retires only while running and the ROM word is present.
  assign retire = (state == S_RUN) && Seq_RomReady;

  // State and output registers; reset wins over any retire in the same cycle.
  always_ff @(posedge Seq_CLOCK_50) begin
    if (Seq_RESET_InHigh) begin
      state          <= S_IDLE;
      Seq_Addr       <= '0;
      Seq_AddrValid  <= 1'b0;
      Seq_Trap       <= 1'b0;
      Seq_CycleCount <= '0;
    end else begin
      state          <= state_nxt;
      Seq_Addr       <= addr_nxt;
      Seq_AddrValid  <= valid_nxt;
      Seq_Trap       <= trap_nxt;
      Seq_CycleCount <= count_nxt;
    end
  end

  // Next-state / next-output selection; everything holds unless retiring.
  always_comb begin
    state_nxt = state;
    addr_nxt  = Seq_Addr;
    valid_nxt = Seq_AddrValid;
    trap_nxt  = Seq_Trap;
    count_nxt = Seq_CycleCount;
    case (state)
      S_IDLE: begin
        // First fetch goes out at address 0.
        state_nxt = S_RUN;
        valid_nxt = 1'b1;
      end
      S_RUN: begin
        if (retire) begin
          if (Seq_CycleCount != '1)
            count_nxt = Seq_CycleCount + DATAWIDTH_COUNT'(1);
          if (Seq_Select == SEL_NEXT)
            addr_nxt = Seq_Addr + DATAWIDTH_ADDR'(1);
          else if (Seq_Select == SEL_JUMP)
            addr_nxt = Seq_JumpAddr;
          else if (Seq_Select == SEL_DECODE)
            addr_nxt = DATAWIDTH_ADDR'({1'b1, Seq_DecodeBits, 2'b00});
          else begin
            // Illegal select: freeze address, drop the request, latch trap.
            state_nxt = S_HALT;
            valid_nxt = 1'b0;
            trap_nxt  = 1'b1;
          end
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cs_address_sequencer.sv
// Directed + randomized bench for cs_address_sequencer against a behavioural model.
module tb_cs_address_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  sel;
  logic [10:0] jmp;
  logic [7:0]  dec;
  logic        rdy;
  logic [10:0] addr;
  logic        valid;
  logic        trap;
  logic [15:0] cnt;

  int checks = 0;
  int errors = 0;

  // Behavioural model: "started" means the first fetch has gone out,
  // "halted" means an illegal select stopped the sequencer.
  bit m_started, m_halted, m_trap, m_valid;
  int m_addr, m_cnt;

  cs_address_sequencer dut (
    .Seq_CLOCK_50     (clk),
    .Seq_RESET_InHigh (rst),
    .Seq_Select       (sel),
    .Seq_JumpAddr     (jmp),
    .Seq_DecodeBits   (dec),
    .Seq_RomReady     (rdy),
    .Seq_Addr         (addr),
    .Seq_AddrValid    (valid),
    .Seq_Trap         (trap),
    .Seq_CycleCount   (cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input bit r, input bit ready, input int s, input int j, input int d);
    if (r) begin
      m_started = 0; m_halted = 0; m_trap = 0; m_valid = 0; m_addr = 0; m_cnt = 0;
    end else if (!m_started) begin
      m_started = 1; m_valid = 1;
    end else if (!m_halted && ready) begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (s == 0)      m_addr = (m_addr + 1) % 2048;
      else if (s == 1) m_addr = j;
      else if (s == 2) m_addr = 1024 + d * 4;
      else begin m_halted = 1; m_trap = 1; m_valid = 0; end
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".addr"},  32'(addr),  32'(m_addr));
    chk({tag, ".valid"}, 32'(valid), 32'(m_valid));
    chk({tag, ".trap"},  32'(trap),  32'(m_trap));
    chk({tag, ".count"}, 32'(cnt),   32'(m_cnt));
  endtask

  // One clock: drive inputs, advance model, sample 1 time unit after the edge.
  task automatic step(input bit r, input bit ready, input int s, input int j, input int d,
                      input bit do_chk, input string tag);
    rst = r; rdy = ready; sel = 2'(s); jmp = 11'(j); dec = 8'(d);
    model_edge(r, ready, s, j, d);
    @(posedge clk); #1;
    if (do_chk) check_all(tag);
  endtask

  initial begin
    rst = 1; rdy = 0; sel = 0; jmp = 0; dec = 0;
    // Reset state
    step(1, 0, 0, 0, 0, 1, "reset");
    // Sequential fetch: 0 (IDLE->RUN), then 1, 2, 3
    for (int i = 0; i < 4; i++) step(0, 1, 0, 0, 0, 1, "seq_next");
    // Wrap 2047 -> 0
    step(0, 1, 1, 2047, 0, 1, "jump_2047");
    step(0, 1, 0, 0, 0, 1, "wrap");
    // Jump and decode dispatch
    step(0, 1, 1, 'h155, 0, 1, "jump_155");
    step(0, 1, 2, 0, 'h83, 1, "decode_83");
    // RomReady low: hold, then jump on 4th cycle
    for (int i = 0; i < 3; i++) step(0, 0, 1, 'h2AA, 0, 1, "stall");
    step(0, 1, 1, 'h2AA, 0, 1, "stall_release");
    // Decode boundaries
    step(0, 1, 2, 0, 'hFF, 1, "decode_ff");
    step(0, 1, 2, 0, 'h00, 1, "decode_00");
    // Illegal select -> HALT, then retire attempts ignored
    step(0, 1, 3, 0, 0, 1, "illegal");
    for (int i = 0; i < 5; i++)
      step(0, 1, $urandom_range(0, 3), $urandom_range(0, 2047), $urandom_range(0, 255), 1, "halt_hold");
    step(1, 1, 0, 0, 0, 1, "reset_after_halt");
    // Reset coinciding with illegal select: reset wins
    step(0, 1, 0, 0, 0, 1, "idle2");
    step(0, 1, 0, 0, 0, 1, "run2");
    step(1, 1, 3, 0, 0, 1, "reset_vs_illegal");
    step(0, 1, 0, 0, 0, 1, "idle3");
    step(1, 1, 0, 0, 0, 1, "reset_vs_retire");

    // Randomized traffic with occasional illegal selects and resets
    for (int i = 0; i < 600; i++) begin
      int s;
      s = ($urandom_range(0, 31) == 0) ? 3 : $urandom_range(0, 2);
      step(($urandom_range(0, 39) == 0) || (m_halted && $urandom_range(0, 7) == 0),
           $urandom_range(0, 3) != 0, s, $urandom_range(0, 2047), $urandom_range(0, 255),
           1, "random");
    end

    // Counter saturation
    step(1, 0, 0, 0, 0, 1, "sat_reset");
    step(0, 1, 0, 0, 0, 1, "sat_idle");
    for (int i = 0; i < 65534; i++)
      step(0, 1, $urandom_range(0, 2), $urandom_range(0, 2047), $urandom_range(0, 255), 0, "");
    check_all("sat_fffe");
    step(0, 1, 0, 0, 0, 1, "sat_ffff");
    step(0, 1, 0, 0, 0, 1, "sat_hold1");
    step(0, 1, 1, 'h7FF, 0, 1, "sat_hold2");
    step(0, 1, 3, 0, 0, 1, "sat_trap");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
